// File: rtl/avalon_mm_pipeline_bridge.sv
// Avalon-MM pipeline bridge.
// The command path goes through a 2-entry skid buffer: an output register plus
// one spare entry. The response path goes through one register stage.
// Outstanding read beats are counted, and reads are held back while their
// burst would push the count past MAX_PENDING_RD.
//
// Handshake semantics (both ports, Avalon-MM pipelined):
//   a command transfers on a clock edge where (read|write) is high and
//   waitrequest is low. While waitrequest is high, the issuer keeps every
//   command field stable. Read beats and write responses are pushed without
//   backpressure.
module avalon_mm_pipeline_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int BURST_W        = 11,
    parameter int MAX_PENDING_RD = 1024,
    localparam int BE_W          = DATA_W / 8,
    localparam int PEND_W        = $clog2(MAX_PENDING_RD + 1)
) (
    input  logic               aclk,
    input  logic               arst,

    input  logic [ADDR_W-1:0]  s_address,
    input  logic [BE_W-1:0]    s_byteenable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [DATA_W-1:0]  s_writedata,
    input  logic [BURST_W-1:0] s_burstcount,
    output logic               s_waitrequest,
    output logic [DATA_W-1:0]  s_readdata,
    output logic [1:0]         s_response,
    output logic               s_readdatavalid,
    output logic               s_writeresponsevalid,

    output logic [ADDR_W-1:0]  m_address,
    output logic [BE_W-1:0]    m_byteenable,
    output logic               m_read,
    output logic               m_write,
    output logic [DATA_W-1:0]  m_writedata,
    output logic [BURST_W-1:0] m_burstcount,
    input  logic               m_waitrequest,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic [1:0]         m_response,
    input  logic               m_readdatavalid,
    input  logic               m_writeresponsevalid,

    output logic [PEND_W-1:0]  pending_rd,
    output logic               rsp_err
);

    // Wide enough to hold pending_rd plus any burst length without overflow.
    localparam int SUM_W = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

    // A read burst larger than the credit pool could never be issued.
    if (MAX_PENDING_RD < 2 ** (BURST_W - 1)) begin : g_bad_cfg
        $fatal(1, "MAX_PENDING_RD must be at least 2**(BURST_W-1)");
    end

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [BE_W-1:0]    be;
        logic [DATA_W-1:0]  wdata;
        logic [BURST_W-1:0] burst;
    } cmd_t;

    cmd_t             in_cmd;
    cmd_t             out_cmd;
    cmd_t             out_cmd_n;
    cmd_t             spare_cmd;
    cmd_t             spare_cmd_n;
    logic             out_valid;
    logic             out_valid_n;
    logic             spare_valid;
    logic             spare_valid_n;
    logic             wait_q;

    logic             accept;
    logic             xfer;
    logic             rd_xfer;
    logic             out_free;
    logic             credit_ok;
    logic             beat_ok;
    logic [SUM_W-1:0] rd_len;
    logic [SUM_W-1:0] pend_ext;
    logic [SUM_W-1:0] pend_next;

    // Capture the upstream command. When read and write are both high, the
    // read wins and the write is dropped.
    always_comb begin
        in_cmd       = '0;
        in_cmd.rd    = s_read;
        in_cmd.wr    = s_write & ~s_read;
        in_cmd.addr  = s_address;
        in_cmd.be    = s_byteenable;
        in_cmd.wdata = s_writedata;
        in_cmd.burst = s_burstcount;
    end

    // Work out read credit and the transfer handshakes on both sides.
    always_comb begin
        accept    = (s_read | s_write) & ~wait_q;
        rd_len    = (out_cmd.burst == '0) ? SUM_W'(1) : SUM_W'(out_cmd.burst);
        pend_ext  = SUM_W'(pending_rd);
        credit_ok = (pend_ext + rd_len) <= SUM_W'(MAX_PENDING_RD);
        m_read    = out_valid & out_cmd.rd & credit_ok;
        m_write   = out_valid & out_cmd.wr;
        xfer      = (m_read | m_write) & ~m_waitrequest;
        rd_xfer   = m_read & ~m_waitrequest;
        out_free  = ~out_valid | xfer;
    end

    assign m_address     = out_cmd.addr;
    assign m_byteenable  = out_cmd.be;
    assign m_writedata   = out_cmd.wdata;
    assign m_burstcount  = out_cmd.burst;
    assign s_waitrequest = wait_q;

    // Skid buffer next state. The spare entry is filled only when the output
    // entry cannot advance, and it always drains into the output entry first,
    // so the order of commands is kept.
    always_comb begin
        out_valid_n   = out_valid;
        out_cmd_n     = out_cmd;
        spare_valid_n = spare_valid;
        spare_cmd_n   = spare_cmd;
        if (out_free) begin
            if (spare_valid) begin
                out_valid_n   = 1'b1;
                out_cmd_n     = spare_cmd;
                spare_valid_n = accept;
                if (accept) begin
                    spare_cmd_n = in_cmd;
                end
            end else begin
                out_valid_n = accept;
                if (accept) begin
                    out_cmd_n = in_cmd;
                end
            end
        end else if (accept) begin
            spare_valid_n = 1'b1;
            spare_cmd_n   = in_cmd;
        end
    end

    // Skid buffer registers. waitrequest mirrors spare occupancy, and it is
    // held high through reset.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            out_valid   <= 1'b0;
            out_cmd     <= '0;
            spare_valid <= 1'b0;
            spare_cmd   <= '0;
            wait_q      <= 1'b1;
        end else begin
            out_valid   <= out_valid_n;
            out_cmd     <= out_cmd_n;
            spare_valid <= spare_valid_n;
            spare_cmd   <= spare_cmd_n;
            wait_q      <= spare_valid_n;
        end
    end

    // Net change to the outstanding-beat count. A beat that arrives when the
    // count is already zero is unexpected, so it does not decrement.
    always_comb begin
        beat_ok   = m_readdatavalid & (pending_rd != '0);
        pend_next = pend_ext
                  + (rd_xfer ? rd_len : '0)
                  - (beat_ok ? SUM_W'(1) : '0);
    end

    // Outstanding read counter and sticky unexpected-beat flag.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            pending_rd <= '0;
            rsp_err    <= 1'b0;
        end else begin
            pending_rd <= PEND_W'(pend_next);
            rsp_err    <= rsp_err | (m_readdatavalid & (pending_rd == '0));
        end
    end

    // Response stage with one cycle of latency. Data and response hold their
    // last value between valid beats.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            s_readdatavalid      <= 1'b0;
            s_writeresponsevalid <= 1'b0;
            s_readdata           <= '0;
            s_response           <= 2'b00;
        end else begin
            s_readdatavalid      <= m_readdatavalid;
            s_writeresponsevalid <= m_writeresponsevalid;
            if (m_readdatavalid) begin
                s_readdata <= m_readdata;
            end
            if (m_readdatavalid | m_writeresponsevalid) begin
                s_response <= m_response;
            end
        end
    end

endmodule

// File: doc/avalon_mm_pipeline_bridge.md
Name: avalon_mm_pipeline_bridge

Overview:
Parametrised Avalon-MM pipeline bridge between one upstream agent port (s_*) and one downstream host port (m_*). It registers the command path through a 2-entry skid buffer and the response path through one register stage. It tracks outstanding read beats and throttles reads against a configurable credit limit. It sits between interconnect segments to break timing paths on Avalon-MM buses.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
BURST_W, 11, burstcount width
MAX_PENDING_RD, 1024, max outstanding read beats; elaboration fatal if < 2**(BURST_W-1)

Ports:
aclk  in  1  clock
arst  in  1  asynchronous reset, active-low
s_address  in  ADDR_W  upstream address
s_byteenable  in  DATA_W/8  upstream byte enables
s_read  in  1  upstream read request
s_write  in  1  upstream write request
s_writedata  in  DATA_W  upstream write data
s_burstcount  in  BURST_W  upstream burst length
s_waitrequest  out  1  upstream stall
s_readdata  out  DATA_W  read data to upstream
s_response  out  2  OKAY/EXOKAY/SLVERR/DECERR
s_readdatavalid  out  1  read beat valid
s_writeresponsevalid  out  1  write response valid
m_address, m_byteenable, m_read, m_write, m_writedata, m_burstcount  out  (same widths)  downstream command
m_waitrequest  in  1  downstream stall
m_readdata  in  DATA_W  downstream read data
m_response  in  2  downstream response
m_readdatavalid  in  1  downstream read beat valid
m_writeresponsevalid  in  1  downstream write response valid
pending_rd  out  $clog2(MAX_PENDING_RD+1)  outstanding read beats
rsp_err  out  1  sticky: unexpected read beat received

Behaviour:
- Reset (arst low, async): s_waitrequest=1; m_read=m_write=0; s_readdatavalid=s_writeresponsevalid=0; s_readdata=0; s_response=OKAY; pending_rd=0; rsp_err=0; skid buffer empty. s_waitrequest drops to 0 on the first aclk edge after release.
- Upstream accept: (s_read|s_write) && !s_waitrequest. s_read and s_write both high is illegal; the read is taken and the write is dropped.
- Skid buffer: output register plus one spare entry. s_waitrequest is registered and equals "spare entry occupied". Minimum command latency is 1 cycle from accept to m_read/m_write high. Sustained throughput is 1 command/cycle when m_waitrequest=0.
- Downstream: the output entry drives m_*. A command transfers when (m_read|m_write) && !m_waitrequest. m_* fields stay stable while m_waitrequest=1.
- Write bursts: every beat is an independent command entry and is forwarded in order. m_burstcount is copied unchanged from the beat's s_burstcount. Writes are not credit-checked.
- Read credit: effective length B = s_burstcount, with 0 treated as 1. A read in the output entry is withheld (m_read=0) while pending_rd + B > MAX_PENDING_RD. Commands behind it stay in order, and no reordering occurs.
- pending_rd update: +B on read transfer, −1 per m_readdatavalid. When both occur in the same cycle, the net change applies.
- Unexpected beat: m_readdatavalid with pending_rd=0 leaves the counter at 0, sets rsp_err (cleared only by reset), and still forwards the beat.
- Response path: m_readdata, m_response, m_readdatavalid and m_writeresponsevalid are registered, giving exactly 1-cycle latency to s_*. There is no response backpressure. s_readdata and s_response hold their last value when not valid.
- Reset mid-operation: all in-flight commands and credits are discarded. Responses arriving after reset release are treated as unexpected (rsp_err).

Test Plan:
- Single read, m_waitrequest=0: s_read@addr 0x100, B=1 -> m_read high the next cycle, pending_rd=1; m_readdatavalid with 0xDEADBEEF -> s_readdatavalid and data one cycle later, pending_rd=0.
- Backpressure: m_waitrequest=1 for 5 cycles, 3 writes (0x1,0x2,0x3) issued back-to-back -> s_waitrequest=1 after 2 accepted; all 3 appear on m_* in order with stable fields; nothing lost or duplicated.
- Credit limit (BURST_W=4, MAX_PENDING_RD=8): read B=8, then read B=1 -> second m_read withheld until the first readdatavalid beat; pending_rd peaks at 8, ends at 0.
- Simultaneous: read issue B=4 in the same cycle as a readdatavalid with pending_rd=3 -> pending_rd=6 next cycle.
- Unexpected beat: m_readdatavalid with pending_rd=0 -> rsp_err=1 sticky, beat forwarded, pending_rd stays 0.
- Async reset asserted mid-burst (pending_rd=5) -> all outputs at reset values immediately, s_waitrequest=1; after release, pending_rd=0 and s_waitrequest=0 one edge later.
